// File: rtl/rotary_pkg.sv
// Shared rotary-encoder definitions: FSM states and the (clk,dt) line levels per phase and direction.
// Levels are packed as {clk, dt}; both lines are active low and idle high.
package rotary_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_PH4  = 3'd4,
    ST_GAP  = 3'd5
  } rotary_state_t;

  localparam logic [1:0] IDLE_LEVEL = 2'b11;

  localparam logic [1:0] UP_PH1_LEVEL = 2'b10;
  localparam logic [1:0] UP_PH2_LEVEL = 2'b00;
  localparam logic [1:0] UP_PH3_LEVEL = 2'b01;
  localparam logic [1:0] UP_PH4_LEVEL = 2'b11;

  localparam logic [1:0] DN_PH1_LEVEL = 2'b01;
  localparam logic [1:0] DN_PH2_LEVEL = 2'b00;
  localparam logic [1:0] DN_PH3_LEVEL = 2'b10;
  localparam logic [1:0] DN_PH4_LEVEL = 2'b11;

  function automatic logic [1:0] phase_level(input rotary_state_t st, input logic dir_up);
    logic [1:0] lvl;
    lvl = IDLE_LEVEL;
    case (st)
      ST_PH1:  lvl = dir_up ? UP_PH1_LEVEL : DN_PH1_LEVEL;
      ST_PH2:  lvl = dir_up ? UP_PH2_LEVEL : DN_PH2_LEVEL;
      ST_PH3:  lvl = dir_up ? UP_PH3_LEVEL : DN_PH3_LEVEL;
      ST_PH4:  lvl = dir_up ? UP_PH4_LEVEL : DN_PH4_LEVEL;
      default: lvl = IDLE_LEVEL;
    endcase
    return lvl;
  endfunction

  // Level held just before entering a phase; differs from the phase level in exactly one line.
  function automatic logic [1:0] prev_level(input rotary_state_t st, input logic dir_up);
    logic [1:0] lvl;
    lvl = IDLE_LEVEL;
    case (st)
      ST_PH2:  lvl = phase_level(ST_PH1, dir_up);
      ST_PH3:  lvl = phase_level(ST_PH2, dir_up);
      ST_PH4:  lvl = phase_level(ST_PH3, dir_up);
      default: lvl = IDLE_LEVEL;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/rotary_step_counter.sv
// Saturating signed pending-step counter; a consume is applied before the new request is range-checked.
module rotary_step_counter #(
  parameter int PEND_W = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     up,
  input  logic                     dn,
  input  logic                     consume,
  output logic signed [PEND_W-1:0] pend,
  output logic                     nonzero,
  output logic                     sign,
  output logic                     dropped
);

  localparam logic signed [PEND_W-1:0] ONE   = PEND_W'(1);
  localparam logic signed [PEND_W-1:0] P_MAX = PEND_W'((2 ** (PEND_W - 1)) - 1);
  localparam logic signed [PEND_W-1:0] N_MAX = -P_MAX;

  logic signed [PEND_W-1:0] pend_reg, pend_next, base;
  logic                     dropped_reg, dropped_next;

  always_comb begin
    base         = pend_reg;
    pend_next    = pend_reg;
    dropped_next = 1'b0;
    // Consume moves one step toward zero before the request is judged.
    if (consume) begin
      base = pend_reg[PEND_W-1] ? (pend_reg + ONE) : (pend_reg - ONE);
    end
    pend_next = base;
    if (up && !dn) begin
      if (base == P_MAX) dropped_next = 1'b1;
      else               pend_next    = base + ONE;
    end else if (dn && !up) begin
      if (base == N_MAX) dropped_next = 1'b1;
      else               pend_next    = base - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      pend_reg    <= '0;
      dropped_reg <= 1'b0;
    end else begin
      pend_reg    <= pend_next;
      dropped_reg <= dropped_next;
    end
  end

  assign pend    = pend_reg;
  assign nonzero = (pend_reg != '0);
  assign sign    = pend_reg[PEND_W-1];
  assign dropped = dropped_reg;

endmodule

// File: rtl/rotary_encoder_emulator.sv
// Quadrature detent generator driving active-low rotary_clk/rotary_dt from buffered step requests.
// Optional ROTARY_BOUNCE_EN adds contact-bounce chatter on the changing line at each phase entry.
module rotary_encoder_emulator
  import rotary_pkg::*;
#(
  parameter int PHASE_CYCLES = 10000,
  parameter int GAP_CYCLES   = 48000,
  parameter int PEND_W       = 4
) (
  input  logic clk,
  input  logic res,
  input  logic step_up,
  input  logic step_dn,
  output logic rotary_clk,
  output logic rotary_dt,
  output logic busy,
  output logic step_done,
  output logic dropped
);

  localparam int CNT_MAX = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  rotary_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dir_reg, dir_next;
  logic [1:0]       lvl_reg, lvl_next;
  logic             busy_reg, done_reg, done_next;
  logic             consume, pend_nonzero, pend_sign;
  logic signed [PEND_W-1:0] pend_unused;

  rotary_step_counter #(.PEND_W(PEND_W)) u_step_counter (
    .clk     (clk),
    .res     (res),
    .up      (step_up),
    .dn      (step_dn),
    .consume (consume),
    .pend    (pend_unused),
    .nonzero (pend_nonzero),
    .sign    (pend_sign),
    .dropped (dropped)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    dir_next   = dir_reg;
    consume    = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (pend_nonzero) begin
          state_next = ST_PH1;
          dir_next   = ~pend_sign;
          consume    = 1'b1;
        end
      end
      ST_PH1: if (cnt_reg == PH_LAST) begin state_next = ST_PH2; cnt_next = '0; end
      ST_PH2: if (cnt_reg == PH_LAST) begin state_next = ST_PH3; cnt_next = '0; end
      ST_PH3: if (cnt_reg == PH_LAST) begin state_next = ST_PH4; cnt_next = '0; end
      ST_PH4: if (cnt_reg == PH_LAST) begin state_next = ST_GAP; cnt_next = '0; end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    lvl_next = phase_level(state_next, dir_next);
`ifdef ROTARY_BOUNCE_EN
    // Odd cycles 1 and 3 of a phase revert the changing line to its previous level.
    if ((state_next inside {ST_PH1, ST_PH2, ST_PH3, ST_PH4}) &&
        (cnt_next < CNT_W'(4)) && cnt_next[0]) begin
      lvl_next = lvl_next ^ (lvl_next ^ prev_level(state_next, dir_next));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      lvl_reg   <= IDLE_LEVEL;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      lvl_reg   <= lvl_next;
      busy_reg  <= (state_next != ST_IDLE);
      done_reg  <= done_next;
    end
  end

  assign rotary_clk = lvl_reg[1];
  assign rotary_dt  = lvl_reg[0];
  assign busy       = busy_reg;
  assign step_done  = done_reg;

endmodule

// File: tb/tb_rotary_encoder_emulator.sv
// Bench for rotary_encoder_emulator: directed scenarios plus random requests against a timeline model.
module tb_rotary_encoder_emulator;

  localparam int P    = 8;
  localparam int G    = 4;
  localparam int W    = 4;
  localparam int PMAX = 7;
  localparam int DETENT = 4 * P + G;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic step_up = 1'b0;
  logic step_dn = 1'b0;
  logic rotary_clk, rotary_dt, busy, step_done, dropped;

  always #5 clk = ~clk;

  rotary_encoder_emulator #(.PHASE_CYCLES(P), .GAP_CYCLES(G), .PEND_W(W)) dut (
    .clk        (clk),
    .res        (res),
    .step_up    (step_up),
    .step_dn    (step_dn),
    .rotary_clk (rotary_clk),
    .rotary_dt  (rotary_dt),
    .busy       (busy),
    .step_done  (step_done),
    .dropped    (dropped)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a detent is a timeline starting at the edge PH1 is entered.
  int t = 0;
  int m_pend = 0;
  bit m_active = 0;
  int m_start = 0;
  bit m_dir = 0;
  bit m_done = 0;
  bit m_drop = 0;

  int n_drop = 0;
  int n_done = 0;
  int n_busy = 0;

  function automatic logic [1:0] level_of(input bit up, input int ph);
    if (ph < 0) return 2'b11;
    case (ph)
      0: return up ? 2'b10 : 2'b01;
      1: return 2'b00;
      2: return up ? 2'b01 : 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [4:0] model_outputs();
    logic [1:0] lvl;
    int off, ph, sub;
    lvl = 2'b11;
    if (m_active) begin
      off = t - m_start;
      if (off < 4 * P) begin
        ph  = off / P;
        sub = off % P;
        lvl = level_of(m_dir, ph);
`ifdef ROTARY_BOUNCE_EN
        if (sub < 4 && (sub % 2) == 1) lvl = level_of(m_dir, ph - 1);
`endif
      end
    end
    return {lvl, m_active, m_done, m_drop};
  endfunction

  task automatic model_edge(input bit u, input bit d, input bit r);
    int consume_dir, base, req;
    t++;
    m_done = 0;
    m_drop = 0;
    if (r) begin
      m_pend = 0;
      m_active = 0;
      return;
    end
    consume_dir = 0;
    if (!m_active && m_pend != 0) begin
      m_active = 1;
      m_start  = t;
      m_dir    = (m_pend > 0);
      consume_dir = m_dir ? 1 : -1;
    end else if (m_active && (t - m_start) == DETENT) begin
      m_active = 0;
      m_done   = 1;
    end
    base = m_pend - consume_dir;
    req  = int'(u) - int'(d);
    if (base + req > PMAX || base + req < -PMAX) m_drop = 1;
    else base = base + req;
    m_pend = base;
  endtask

  task automatic tick(input bit u, input bit d, input bit r);
    logic [4:0] obs, expv;
    step_up = u;
    step_dn = d;
    res     = r;
    @(posedge clk);
    model_edge(u, d, r);
    #1;
    step_up = 1'b0;
    step_dn = 1'b0;
    res     = 1'b0;
    obs  = {rotary_clk, rotary_dt, busy, step_done, dropped};
    expv = model_outputs();
    n_drop += int'(dropped);
    n_done += int'(step_done);
    n_busy += int'(busy);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL cycle%0d {clk,dt,busy,done,dropped} observed=%b expected=%b", t, obs, expv);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((m_active || m_pend != 0) && budget < 2000) begin
      tick(0, 0, 0);
      budget++;
    end
    checks++;
    assert (budget < 2000) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected<2000", budget);
    end
    idle_cycles(2);
  endtask

  task automatic check_count(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset
    tick(0, 0, 1);
    tick(0, 0, 1);
    checks++;
    assert ({rotary_clk, rotary_dt, busy, step_done, dropped} === 5'b11000) else begin
      errors++;
      $error("FAIL reset_values observed=%b expected=%b",
             {rotary_clk, rotary_dt, busy, step_done, dropped}, 5'b11000);
    end
    idle_cycles(3);

    // Single up, then single down
    n_done = 0;
    tick(1, 0, 0);
    drain();
    check_count("single_up_done", n_done, 1);
    n_done = 0;
    tick(0, 1, 0);
    drain();
    check_count("single_dn_done", n_done, 1);

    // Simultaneous up+down while idle cancels
    n_busy = 0; n_drop = 0;
    tick(1, 1, 0);
    idle_cycles(20);
    check_count("cancel_busy", n_busy, 0);
    check_count("cancel_dropped", n_drop, 0);

    // Three back-to-back ups
    n_done = 0;
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    drain();
    check_count("three_up_done", n_done, 3);

    // Saturation while busy, then two downs
    n_done = 0; n_drop = 0;
    tick(1, 0, 0);
    idle_cycles(3);
    for (int i = 0; i < 9; i++) tick(1, 0, 0);
    tick(0, 1, 0); tick(0, 1, 0);
    drain();
    check_count("sat_dropped", n_drop, 2);
    check_count("sat_done", n_done, 6);

    // Reset in PH2 abandons the detent and pending steps
    tick(1, 0, 0); tick(1, 0, 0);
    idle_cycles(P + 3);
    tick(0, 0, 1);
    n_busy = 0; n_done = 0;
    idle_cycles(100);
    check_count("reset_mid_busy", n_busy, 0);
    check_count("reset_mid_done", n_done, 0);

    // Random requests
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 999) == 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
